data_mem_responder: RTL and testbench

Memory-side responder for the processor's load/store path. Accepts the `memRead`/`memWrite` requests issued by the control unit for LDM/STM instructions and performs the access on an internal single-port data array with a fixed, parameterizable latency. Returns read data with a one-cycle `memReady` completion pulse, and raises `memBusy` so the datapath can hold the PC while an access is in flight.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder_sync_ram.sv | 23 ++
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and default widths for the load/store memory path.
package mem_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory responder (slave).
interface data_mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  memRead;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;
    logic                  memReady;
    logic                  memBusy;
    logic                  memError;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, memReady, memBusy, memError
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, memReady, memBusy, memError
    );

endinterface

// File: rtl/data_mem_responder_sync_ram.sv
// Single-port data array with a registered read port and no reset.
module sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Write on we, and always register the old word at addr for reads.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: accepts one load/store at a time, completes it after LATENCY cycles.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                 clock,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                state_q;
    op_t                   op_q;
    logic [3:0]            count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] readData_q;
    logic                  memReady_q;
    logic                  memBusy_q;
    logic                  memError_q;

    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [DATA_WIDTH-1:0] ramRdata;
    logic                  ramWe;

    // In IDLE the array is addressed straight from the bus so a LATENCY=1 read
    // has its word ready in the DONE cycle; otherwise the latched address is used.
    // The write enable is gated by reset so an aborted store never commits.
    assign ramAddr = (state_q == IDLE) ? bus.address : addr_q;
    assign ramWe   = (state_q == DONE) && (op_q == OP_WRITE) && rst;

    sync_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (wdata_q),
        .rdata (ramRdata)
    );

    // Request FSM with latency counter, request latches and registered status outputs.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            count_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readData_q <= '0;
            memReady_q <= 1'b0;
            memBusy_q  <= 1'b0;
            memError_q <= 1'b0;
        end else begin
            memReady_q <= 1'b0;
            memError_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.memRead && bus.memWrite) begin
                        memError_q <= 1'b1;
                    end else if (bus.memRead || bus.memWrite) begin
                        addr_q    <= bus.address;
                        memBusy_q <= 1'b1;
                        if (bus.memWrite) begin
                            wdata_q <= bus.writeData;
                            op_q    <= OP_WRITE;
                        end else begin
                            op_q    <= OP_READ;
                        end
                        if (LATENCY == 1) begin
                            state_q    <= DONE;
                            count_q    <= '0;
                            memReady_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            count_q <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q    <= DONE;
                        memReady_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    memBusy_q <= 1'b0;
                    if (op_q == OP_READ) begin
                        readData_q <= ramRdata;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // During a read's DONE cycle the fresh array word is shown; otherwise the held value.
    assign bus.readData = ((state_q == DONE) && (op_q == OP_READ)) ? ramRdata : readData_q;
    assign bus.memReady = memReady_q;
    assign bus.memBusy  = memBusy_q;
    assign bus.memError = memError_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: table vectors, reset abort, LATENCY=1 streaming, random traffic vs. array model.
module tb_data_mem_responder;

    localparam int LAT2 = 2;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    always #5 clock = ~clock;

    data_mem_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus2 ();
    data_mem_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();

    data_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LATENCY(LAT2)) dut2 (
        .clock (clock),
        .rst   (rst),
        .bus   (bus2)
    );

    data_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
        .clock (clock),
        .rst   (rst),
        .bus   (bus1)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expData;
    } vec_t;

    int passCount  = 0;
    int checkCount = 0;

    // Reference: plain array of word contents plus the last completed read value.
    logic [7:0] model [256];
    logic [7:0] lastRead2 = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic dropRequest2();
        bus2.memRead  = 1'b0;
        bus2.memWrite = 1'b0;
    endtask

    // One access on the LATENCY=2 responder, checked cycle by cycle against the model.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a,
                                 input logic [7:0] d, input bit junk);
        @(negedge clock);
        bus2.memRead   = rd;
        bus2.memWrite  = wr;
        bus2.address   = a;
        bus2.writeData = d;
        @(posedge clock);
        @(negedge clock);
        if (rd && wr) begin
            checkOutput("errPulse", 32'(bus2.memError), 32'd1);
            checkOutput("errBusy", 32'(bus2.memBusy), 32'd0);
            checkOutput("errReady", 32'(bus2.memReady), 32'd0);
            dropRequest2();
            @(negedge clock);
            checkOutput("errOneCycle", 32'(bus2.memError), 32'd0);
            checkOutput("errData", 32'(bus2.readData), 32'(lastRead2));
            return;
        end
        checkOutput("noErr", 32'(bus2.memError), 32'd0);
        if (junk) begin
            bus2.memRead   = 1'b1;
            bus2.memWrite  = 1'b0;
            bus2.address   = 8'($urandom);
            bus2.writeData = 8'($urandom);
        end else begin
            dropRequest2();
        end
        for (int k = 1; k < LAT2; k++) begin
            checkOutput("waitBusy", 32'(bus2.memBusy), 32'd1);
            checkOutput("waitReady", 32'(bus2.memReady), 32'd0);
            checkOutput("waitData", 32'(bus2.readData), 32'(lastRead2));
            @(negedge clock);
        end
        dropRequest2();
        checkOutput("doneReady", 32'(bus2.memReady), 32'd1);
        checkOutput("doneBusy", 32'(bus2.memBusy), 32'd1);
        if (wr) begin
            model[a] = d;
        end else begin
            lastRead2 = model[a];
        end
        checkOutput(wr ? "writeKeepsData" : "readData", 32'(bus2.readData), 32'(lastRead2));
        @(negedge clock);
        checkOutput("afterReady", 32'(bus2.memReady), 32'd0);
        checkOutput("afterBusy", 32'(bus2.memBusy), 32'd0);
        checkOutput("afterData", 32'(bus2.readData), 32'(lastRead2));
    endtask

    vec_t vecs [10];

    initial begin
        bus2.memRead = 1'b0; bus2.memWrite = 1'b0; bus2.address = '0; bus2.writeData = '0;
        bus1.memRead = 1'b0; bus1.memWrite = 1'b0; bus1.address = '0; bus1.writeData = '0;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h77, 8'h5A};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 1'b1, 8'h10, 8'hC3, 8'h5A};
        vecs[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hC3};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rstReady", 32'(bus2.memReady), 32'd0);
        checkOutput("rstBusy", 32'(bus2.memBusy), 32'd0);
        checkOutput("rstError", 32'(bus2.memError), 32'd0);
        checkOutput("rstData", 32'(bus2.readData), 32'd0);
        checkOutput("rstData1", 32'(bus1.readData), 32'd0);
        rst = 1'b1;

        // Table vectors (junk on the bus while busy for odd rows)
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, bit'(i % 2));
            checkOutput("tableData", 32'(bus2.readData), 32'(vecs[i].expData));
        end

        // Reset during the WAIT cycle of a store aborts it
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h11, 1'b0);
        @(negedge clock);
        bus2.memWrite = 1'b1; bus2.address = 8'h20; bus2.writeData = 8'h3C;
        @(posedge clock);
        @(negedge clock);
        checkOutput("abortBusyBefore", 32'(bus2.memBusy), 32'd1);
        rst = 1'b0;
        dropRequest2();
        @(negedge clock);
        lastRead2 = 8'h00;
        checkOutput("abortReady", 32'(bus2.memReady), 32'd0);
        checkOutput("abortBusy", 32'(bus2.memBusy), 32'd0);
        checkOutput("abortError", 32'(bus2.memError), 32'd0);
        checkOutput("abortData", 32'(bus2.readData), 32'd0);
        rst = 1'b1;
        @(negedge clock);
        checkOutput("abortNoReady", 32'(bus2.memReady), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("abortOldValue", 32'(bus2.readData), 32'h11);

        // LATENCY=1: store, then a held load completes every second cycle
        @(negedge clock);
        bus1.memWrite = 1'b1; bus1.address = 8'h05; bus1.writeData = 8'hC3;
        @(posedge clock);
        @(negedge clock);
        checkOutput("l1WrReady", 32'(bus1.memReady), 32'd1);
        checkOutput("l1WrData", 32'(bus1.readData), 32'd0);
        bus1.memWrite = 1'b0;
        @(negedge clock);
        checkOutput("l1WrIdle", 32'(bus1.memBusy), 32'd0);
        bus1.memRead = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            checkOutput("l1Ready", 32'(bus1.memReady), 32'(k % 2));
            checkOutput("l1Busy", 32'(bus1.memBusy), 32'(k % 2));
            checkOutput("l1Data", 32'(bus1.readData), 32'hC3);
        end
        bus1.memRead = 1'b0;
        @(negedge clock);
        checkOutput("l1Stopped", 32'(bus1.memReady), 32'd0);

        // Random traffic over a 16-word window, all words initialised first
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h30 + i), 8'($urandom), bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) begin
            logic isWr;
            isWr = 1'($urandom_range(0, 1));
            applyStimulus(~isWr, isWr, 8'(8'h30 + $urandom_range(0, 15)), 8'($urandom),
                          bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
